scope_trigger_ctrl: RTL

//  Trigger and capture sequencer for one scope channel. Takes ADC samples with a valid strobe and writes them into
//  a circular capture RAM (DEPTH words). It keeps PRE_TRIG pre-trigger samples and detects a level crossing.
//  It then fills the rest of the RAM and holds the frame until the VGA sample path acknowledges it has read it.

---
 rtl/scope_trigger_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/scope_trigger_ctrl.sv
// Trigger and capture sequencer for one scope channel.
// Streams samples into a circular RAM and holds each triggered frame.
module scope_trigger_ctrl #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 10,
  parameter int PRE_TRIG = 256,
  parameter int HYST     = 8,
  parameter int AUTO_TO  = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [1:0]        trig_mode,
  input  logic              arm,
  input  logic              stop,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              capture_done,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              forced_trig,
  output logic [2:0]        state_out
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;
  localparam int AC_W   = $clog2(AUTO_TO + 1);

  localparam logic [DATA_W-1:0] HYST_V = DATA_W'(HYST);
  localparam logic [DATA_W-1:0] MAX_V  = '1;
  localparam logic [ADDR_W-1:0] PRE_V  = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_V = ADDR_W'(POST_N);
  localparam logic [AC_W-1:0]   AUTO_V = AC_W'(AUTO_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [AC_W-1:0]   auto_cnt;
  logic              hyst_ok;
  logic [DATA_W-1:0] prev;

  logic              active;
  logic              accept;
  logic              auto_mode;
  logic              rise_hit;
  logic              fall_hit;
  logic              real_hit;
  logic              auto_hit;
  logic              fire;
  logic              arm_set;
  logic [DATA_W-1:0] lvl_lo;
  logic [DATA_W-1:0] lvl_hi;

  assign state_out = state;

  always_comb begin
    active = (state == S_PREFILL) ||
             (state == S_ARMED) ||
             (state == S_POST);
    accept    = sample_valid && !stop && active;
    auto_mode = (trig_mode == 2'b00);
    lvl_lo = (trig_level >= HYST_V) ?
             trig_level - HYST_V : '0;
    lvl_hi = (trig_level >= MAX_V - HYST_V) ?
             MAX_V : trig_level + HYST_V;
    rise_hit = hyst_ok && (prev < trig_level) &&
               (sample_data >= trig_level);
    fall_hit = hyst_ok && (prev > trig_level) &&
               (sample_data <= trig_level);
    real_hit = trig_edge ? fall_hit : rise_hit;
    auto_hit = auto_mode && (auto_cnt == AUTO_V);
    fire     = real_hit || auto_hit;
    arm_set  = trig_edge ? (sample_data >= lvl_hi) :
                           (sample_data <= lvl_lo);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      auto_cnt     <= '0;
      hyst_ok      <= 1'b0;
      prev         <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      capture_done <= 1'b0;
      start_addr   <= '0;
      trig_addr    <= '0;
      forced_trig  <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= ptr;
        wr_data <= sample_data;
        ptr     <= ptr + ADDR_W'(1);
        prev    <= sample_data;
      end
      if (stop) begin
        state        <= S_IDLE;
        capture_done <= 1'b0;
        forced_trig  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (arm) begin
              state        <= S_PREFILL;
              pre_cnt      <= '0;
              post_cnt     <= '0;
              auto_cnt     <= '0;
              capture_done <= 1'b0;
              forced_trig  <= 1'b0;
            end
          end
          S_PREFILL: begin
            if (accept) begin
              pre_cnt <= pre_cnt + ADDR_W'(1);
              if (pre_cnt == PRE_V - ADDR_W'(1)) begin
                state    <= S_ARMED;
                hyst_ok  <= 1'b0;
                auto_cnt <= '0;
              end
            end
          end
          S_ARMED: begin
            if (accept) begin
              if (arm_set) hyst_ok <= 1'b1;
              if (auto_mode) auto_cnt <= auto_cnt + AC_W'(1);
              if (fire) begin
                trig_addr   <= ptr;
                start_addr  <= ptr - PRE_V;
                forced_trig <= !real_hit;
                post_cnt    <= POST_V;
                // frame is exactly DEPTH words: pre + trigger + post
                state        <= (POST_N == 0) ? S_DONE : S_POST;
                capture_done <= (POST_N == 0);
              end
            end
          end
          S_POST: begin
            if (accept) begin
              post_cnt <= post_cnt - ADDR_W'(1);
              if (post_cnt == ADDR_W'(1)) begin
                state        <= S_DONE;
                capture_done <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (frame_ack) begin
              capture_done <= 1'b0;
              forced_trig  <= 1'b0;
              pre_cnt      <= '0;
              state <= (trig_mode == 2'b10) ? S_IDLE : S_PREFILL;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
